// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and parity-mode codes for the UART transmitter
package uart_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - tick counter with programmable terminal count and one-cycle done flag
module uart_bit_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count;

    // done fires on the tick that completes the period; the counter wraps so the next state starts at 0
    assign done = tick && !clear && (count == terminal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer; parity bit built only with UART_TX_PARITY_EN defined
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int N_TICKS = 16,
    parameter int NB_TICK = $clog2(N_TICKS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_stop2,
    input  logic [1:0]         i_parity,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_tx_done,
    output logic               o_tx
);

    localparam int NB_BIT = $clog2(NB_DATA);
    // one extra bit so the timer can also count a double-length stop period
    localparam int NB_TMR = NB_TICK + 1;
    localparam logic [NB_TMR-1:0] TERM_1   = NB_TMR'(N_TICKS - 1);
    localparam logic [NB_TMR-1:0] TERM_2   = NB_TMR'(2 * N_TICKS - 1);
    localparam logic [NB_BIT-1:0] LAST_BIT = NB_BIT'(NB_DATA - 1);

    state_t              state;
    logic [NB_DATA-1:0]  shreg;
    logic [NB_BIT-1:0]   bit_cnt;
    logic                stop2_q;
    logic [NB_TMR-1:0]   terminal;
    logic                bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en;
    logic par_bit;
`else
    logic parity_unused;
    assign parity_unused = ^i_parity;
`endif

    assign o_ready  = (state == IDLE);
    assign o_busy   = !o_ready;
    assign terminal = (state == STOP && stop2_q) ? TERM_2 : TERM_1;

    uart_bit_timer #(
        .W(NB_TMR)
    ) u_bit_timer (
        .clk     (i_clock),
        .rst     (i_reset),
        .clear   (state == IDLE),
        .tick    (i_tick),
        .terminal(terminal),
        .done    (bit_done)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop2_q   <= 1'b0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (i_valid) begin
                        shreg   <= i_data;
                        stop2_q <= i_stop2;
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        par_en  <= parity_enabled(i_parity);
                        par_bit <= (^i_data) ^ (i_parity == PAR_ODD);
`endif
                        o_tx    <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        o_tx  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en) begin
                                o_tx  <= par_bit;
                                state <= PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= STOP;
                            end
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        o_tx  <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        o_tx_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - bench for uart_tx_framer: frame-level reference model, directed and random traffic
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       valid0 = 1'b0, stop2_0 = 1'b0;
    logic [7:0] data0 = '0;
    logic [1:0] par0 = '0;
    logic       valid1 = 1'b0, stop2_1 = 1'b0;
    logic [4:0] data1 = '0;
    logic [1:0] par1 = '0;
    logic       tx0, ready0, busy0, done0;
    logic       tx1, ready1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_framer #(.NB_DATA(8), .N_TICKS(16)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data0), .i_valid(valid0),
        .i_stop2(stop2_0), .i_parity(par0), .o_ready(ready0), .o_busy(busy0),
        .o_tx_done(done0), .o_tx(tx0)
    );

    uart_tx_framer #(.NB_DATA(5), .N_TICKS(4)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data1), .i_valid(valid1),
        .i_stop2(stop2_1), .i_parity(par1), .o_ready(ready1), .o_busy(busy1),
        .o_tx_done(done1), .o_tx(tx1)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of (line level, tick length) segments
    int   seg_lvl [2][16];
    int   seg_len [2][16];
    int   seg_n   [2];
    int   seg_i   [2];
    int   tcnt    [2];
    bit   m_busy  [2];
    logic m_tx    [2];
    logic m_done  [2];

    task automatic model_step(input int d, input logic v, input logic [8:0] dat, input logic s2,
                              input logic [1:0] p, input int nb, input int nt);
        int n;
        int pv;
        m_done[d] = 1'b0;
        if (!m_busy[d]) begin
            if (v) begin
                n = 0;
                seg_lvl[d][n] = 0; seg_len[d][n] = nt; n++;
                pv = 0;
                for (int i = 0; i < nb; i++) begin
                    seg_lvl[d][n] = int'(dat[i]); seg_len[d][n] = nt; n++;
                    pv = pv ^ int'(dat[i]);
                end
                if (PAR_EN && (p == 2'b01 || p == 2'b10)) begin
                    seg_lvl[d][n] = (p == 2'b10) ? 1 - pv : pv; seg_len[d][n] = nt; n++;
                end
                seg_lvl[d][n] = 1; seg_len[d][n] = s2 ? 2 * nt : nt; n++;
                seg_n[d]  = n;
                seg_i[d]  = 0;
                tcnt[d]   = 0;
                m_busy[d] = 1'b1;
                m_tx[d]   = 1'b0;
            end
        end else if (tick) begin
            tcnt[d]++;
            if (tcnt[d] == seg_len[d][seg_i[d]]) begin
                tcnt[d] = 0;
                seg_i[d]++;
                if (seg_i[d] == seg_n[d]) begin
                    m_busy[d] = 1'b0;
                    m_done[d] = 1'b1;
                    m_tx[d]   = 1'b1;
                end else begin
                    m_tx[d] = (seg_lvl[d][seg_i[d]] != 0);
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0;
                m_tx[d]   = 1'b1;
                m_done[d] = 1'b0;
            end
        end else begin
            model_step(0, valid0, {1'b0, data0}, stop2_0, par0, 8, 16);
            model_step(1, valid1, {4'b0, data1}, stop2_1, par1, 5, 4);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check1("cyc_tx0", tx0, m_tx[0]);
            check1("cyc_ready0", ready0, !m_busy[0]);
            check1("cyc_busy0", busy0, m_busy[0]);
            check1("cyc_done0", done0, m_done[0]);
            check1("cyc_tx1", tx1, m_tx[1]);
            check1("cyc_ready1", ready1, !m_busy[1]);
            check1("cyc_busy1", busy1, m_busy[1]);
            check1("cyc_done1", done1, m_done[1]);
        end
    end

    logic cap_tx [0:255];
    logic cap_done [0:255];
    logic cap_ready [0:255];

    task automatic capture(input int d, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]    = (d == 0) ? tx0 : tx1;
            cap_done[i]  = (d == 0) ? done0 : done1;
            cap_ready[i] = (d == 0) ? ready0 : ready1;
            if (i == pulse_at) begin
                valid0 = 1'b1;
                data0  = 8'hFF;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                valid0 = 1'b0;
            end
        end
    endtask

    task automatic start0(input logic [7:0] d, input logic s2, input logic [1:0] p);
        @(posedge clk); #2;
        valid0 = 1'b1; data0 = d; stop2_0 = s2; par0 = p;
        @(posedge clk); #2;
        valid0 = 1'b0;
    endtask

    task automatic start1(input logic [4:0] d, input logic s2, input logic [1:0] p);
        @(posedge clk); #2;
        valid1 = 1'b1; data1 = d; stop2_1 = s2; par1 = p;
        @(posedge clk); #2;
        valid1 = 1'b0;
    endtask

    function automatic int count_level(input int lo, input int hi, input logic lvl);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (cap_tx[i] === lvl) c++;
        return c;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic c3_bits [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic f5_bits [7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] d1, d2;
        int par_end, f5_end, rand_done;

        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check1("reset_tx", tx0, 1'b1);
        check1("reset_ready", ready0, 1'b1);
        check1("reset_busy", busy0, 1'b0);
        check1("reset_done", done0, 1'b0);
        check1("reset_tx5", tx1, 1'b1);

        tick = 1'b1;

        // 8N1 0xA5, one tick per cycle
        start0(8'hA5, 1'b0, 2'b00);
        capture(0, 161, -1);
        for (int b = 0; b < 10; b++)
            check_int("a5_bit_len", count_level(b * 16, b * 16 + 15, a5_bits[b]), 16);
        check_int("a5_done_count", count_done(0, 160), 1);
        check1("a5_done_at_end", cap_done[160], 1'b1);

        // parity bit position holds the parity value when built with it, else the stop level
        par_end = PAR_EN ? 176 : 160;
        start0(8'h07, 1'b0, 2'b01);
        capture(0, 177, -1);
        check1("even_parity_07", cap_tx[152], 1'b1);
        check1("even_done_pos", cap_done[par_end], 1'b1);
        start0(8'h07, 1'b0, 2'b10);
        capture(0, 177, -1);
        check1("odd_parity_07", cap_tx[152], PAR_EN ? 1'b0 : 1'b1);
        check1("odd_done_pos", cap_done[par_end], 1'b1);
        repeat (20) @(posedge clk);

        // two stop bits, valid held so the next frame follows immediately
        d1 = 8'($urandom); d2 = 8'($urandom);
        @(posedge clk); #2;
        valid0 = 1'b1; data0 = d1; stop2_0 = 1'b1; par0 = 2'b00;
        @(posedge clk); #2;
        data0 = d2; stop2_0 = 1'b0;
        capture(0, 178, -1);
        valid0 = 1'b0;
        for (int i = 0; i < 8; i++) check1("stop2_data_bit", cap_tx[24 + 16 * i], d1[i]);
        check_int("stop2_len", count_level(144, 175, 1'b1), 32);
        check_int("stop2_done_count", count_done(0, 177), 1);
        check1("stop2_done_pos", cap_done[176], 1'b1);
        check1("stop2_ready_at_done", cap_ready[176], 1'b1);
        check1("b2b_start_bit", cap_tx[177], 1'b0);
        check1("b2b_busy", cap_ready[177], 1'b0);
        repeat (170) @(posedge clk);

        // valid pulsed mid-frame with 0xFF is ignored
        start0(8'h3C, 1'b0, 2'b00);
        capture(0, 161, 50);
        for (int b = 0; b < 10; b++) check1("midvalid_bit", cap_tx[b * 16 + 8], c3_bits[b]);
        check1("midvalid_done_pos", cap_done[160], 1'b1);

        // reset in the middle of data bit 3
        start0(8'h52, 1'b0, 2'b00);
        repeat (69) @(negedge clk);
        check1("pre_reset_bit3", tx0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check1("abort_tx", tx0, 1'b1);
        check1("abort_ready", ready0, 1'b1);
        check1("abort_busy", busy0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        capture(0, 200, -1);
        check_int("abort_no_done", count_done(0, 199), 0);
        check_int("abort_line_idle", count_level(0, 199, 1'b1), 200);

        // 5 data bits, N_TICKS=4, parity requested
        f5_end = PAR_EN ? 32 : 28;
        start1(5'b10110, 1'b0, 2'b01);
        capture(1, 33, -1);
        for (int b = 0; b < 7; b++) check1("nb5_bit", cap_tx[b * 4 + 2], f5_bits[b]);
        check1("nb5_done_pos", cap_done[f5_end], 1'b1);
        check_int("nb5_done_count", count_done(0, 32), 1);

        // random traffic with irregular ticks
        rand_done = 0;
        for (int c = 0; c < 16000; c++) begin
            @(posedge clk); #2;
            if (done0 === 1'b1) rand_done++;
            tick    = 1'($urandom_range(0, 1));
            valid0  = ($urandom_range(0, 7) == 0);
            data0   = 8'($urandom);
            stop2_0 = 1'($urandom_range(0, 1));
            par0    = 2'($urandom_range(0, 3));
            valid1  = ($urandom_range(0, 5) == 0);
            data1   = 5'($urandom);
            stop2_1 = 1'($urandom_range(0, 1));
            par1    = 2'($urandom_range(0, 3));
            rst     = (c >= 8000 && c < 8002);
        end
        check1("rand_frames_seen", rand_done > 10, 1'b1);
        valid0 = 1'b0; valid1 = 1'b0; tick = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
